// File: rtl/imem_loader.sv
// Instruction memory loader: accepts a length-prefixed, XOR-checksummed byte stream and
// writes it into instruction memory as little-endian 32-bit words while holding the CPU.
module imem_loader #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  im_we,
    output logic [31:0]           im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    localparam logic [16:0]         MAX_WORDS = 17'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE_WORD  = 1;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          lane_q, lane_d;
    logic [7:0]          csum_q, csum_d;
    logic [23:0]         word_q, word_d;
    logic                im_we_q, im_we_d;
    logic [31:0]         im_addr_q, im_addr_d;
    logic [31:0]         im_wdata_q, im_wdata_d;
    logic [ADDR_WIDTH:0] words_q, words_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                rx_ready_q, rx_ready_d;
    logic                cpu_hold_q, cpu_hold_d;

    logic                accept;
    logic [15:0]         len_full;
    logic [ADDR_WIDTH:0] words_inc;

    assign accept    = rx_valid & rx_ready_q;
    assign len_full  = {rx_data, len_q[7:0]};
    assign words_inc = words_q + ONE_WORD;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        lane_d     = lane_q;
        csum_d     = csum_q;
        word_d     = word_q;
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;
        words_d    = words_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_LEN0;
                    words_d = '0;
                    csum_d  = '0;
                    lane_d  = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d[15:8] = rx_data;
                    if ({1'b0, len_full} > MAX_WORDS) begin
                        state_d = S_ERROR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    csum_d = csum_q ^ rx_data;
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: word_d[7:0]   = rx_data;
                        2'd1: word_d[15:8]  = rx_data;
                        2'd2: word_d[23:16] = rx_data;
                        default: begin
                            // Word complete: the write pulse goes out on the next cycle
                            // while the byte stream keeps flowing.
                            im_we_d    = 1'b1;
                            im_wdata_d = {rx_data, word_q};
                            im_addr_d  = BASE_ADDR + 32'({words_q, 2'b00});
                            words_d    = words_inc;
                            if (17'(words_inc) == {1'b0, len_q}) begin
                                state_d = S_CHECK;
                            end
                        end
                    endcase
                end
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rx_ready_d = (state_d == S_LEN0) || (state_d == S_LEN1) ||
                     (state_d == S_DATA) || (state_d == S_CHECK);
        cpu_hold_d = (state_d != S_DONE);
        done_d     = (state_d == S_DONE);
        error_d    = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            lane_q     <= '0;
            csum_q     <= '0;
            word_q     <= '0;
            im_we_q    <= 1'b0;
            im_addr_q  <= '0;
            im_wdata_q <= '0;
            words_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            rx_ready_q <= 1'b0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            lane_q     <= lane_d;
            csum_q     <= csum_d;
            word_q     <= word_d;
            im_we_q    <= im_we_d;
            im_addr_q  <= im_addr_d;
            im_wdata_q <= im_wdata_d;
            words_q    <= words_d;
            done_q     <= done_d;
            error_q    <= error_d;
            rx_ready_q <= rx_ready_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = im_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of frames with expected status and writes,
// plus hand sequences for reset-mid-load, write latency and the maximum-length boundary.
module tb_imem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total  = 0;
    int n_passed = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    // Write monitor samples on the falling edge, away from the update edge.
    always @(negedge clk) begin
        if (im_we === 1'b1) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
        end
    end

    typedef struct {
        int                nbytes;
        logic [0:15][7:0]  bytes;
        bit                gaps;
        logic              exp_done;
        logic              exp_error;
        logic [8:0]        exp_words;
        int                exp_nwr;
        logic [0:2][31:0]  exp_addr;
        logic [0:2][31:0]  exp_data;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_passed++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Sends n bytes; counts cycles where a valid byte waited on rx_ready low.
    task automatic send_bytes(input logic [0:15][7:0] b, input int n, input bit gaps,
                              output int stalls);
        int  waited;
        bit  got;
        stalls = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            rx_data  = b[i];
            rx_valid = 1'b1;
            waited   = 0;
            got      = 1'b0;
            while (!got) begin
                @(negedge clk);
                if (rx_ready === 1'b1) begin
                    got = 1'b1;
                end else begin
                    stalls++;
                    waited++;
                    if (waited > 20) begin
                        n_total++;
                        $display("FAIL rx_ready_timeout: byte %0d not accepted after %0d cycles", i, waited);
                        rx_valid = 1'b0;
                        return;
                    end
                end
            end
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
    endtask

    int stalls;

    initial begin
        // Frames: LEN_LO, LEN_HI, data bytes, checksum (padded to 16 bytes).
        vecs[0] = '{7,  {8'h01,8'h00,8'h13,8'h05,8'hA0,8'h00,8'hB6,{9{8'h00}}}, 1'b0,
                    1'b1, 1'b0, 9'd1, 1, {32'h0,32'h0,32'h0}, {32'h00A0_0513,32'h0,32'h0}};
        vecs[1] = '{11, {8'h02,8'h00,8'h93,8'h00,8'h00,8'h00,8'h13,8'h01,8'h10,8'h00,8'h91,{5{8'h00}}}, 1'b0,
                    1'b1, 1'b0, 9'd2, 2, {32'h0,32'h4,32'h0}, {32'h0000_0093,32'h0010_0113,32'h0}};
        vecs[2] = '{7,  {8'h01,8'h00,8'h44,8'h33,8'h22,8'h11,8'h00,{9{8'h00}}}, 1'b0,
                    1'b0, 1'b1, 9'd1, 1, {32'h0,32'h0,32'h0}, {32'h1122_3344,32'h0,32'h0}};
        vecs[3] = '{7,  {8'h01,8'h00,8'h44,8'h33,8'h22,8'h11,8'h44,{9{8'h00}}}, 1'b0,
                    1'b1, 1'b0, 9'd1, 1, {32'h0,32'h0,32'h0}, {32'h1122_3344,32'h0,32'h0}};
        vecs[4] = '{2,  {8'h01,8'h01,{14{8'h00}}}, 1'b0,
                    1'b0, 1'b1, 9'd0, 0, {32'h0,32'h0,32'h0}, {32'h0,32'h0,32'h0}};
        vecs[5] = '{3,  {8'h00,8'h00,8'h00,{13{8'h00}}}, 1'b0,
                    1'b1, 1'b0, 9'd0, 0, {32'h0,32'h0,32'h0}, {32'h0,32'h0,32'h0}};
        vecs[6] = '{3,  {8'h00,8'h00,8'h01,{13{8'h00}}}, 1'b0,
                    1'b0, 1'b1, 9'd0, 0, {32'h0,32'h0,32'h0}, {32'h0,32'h0,32'h0}};
        vecs[7] = '{15, {8'h03,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,
                         8'h09,8'h0A,8'h0B,8'h0C,8'h0C,8'h00}, 1'b0,
                    1'b1, 1'b0, 9'd3, 3, {32'h0,32'h4,32'h8}, {32'h0403_0201,32'h0807_0605,32'h0C0B_0A09}};
        vecs[8] = vecs[7];
        vecs[8].gaps = 1'b1;

        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_im_we", 32'(im_we), 32'd0);
        check("rst_im_addr", im_addr, 32'h0);
        check("rst_im_wdata", im_wdata, 32'h0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            wr_addr.delete();
            wr_data.delete();
            pulse_start();
            check($sformatf("v%0d_start_hold", i), 32'(cpu_hold), 32'd1);
            check($sformatf("v%0d_start_done", i), 32'(done), 32'd0);
            check($sformatf("v%0d_start_ready", i), 32'(rx_ready), 32'd1);
            send_bytes(vecs[i].bytes, vecs[i].nbytes, vecs[i].gaps, stalls);
            @(negedge clk);
            if (!vecs[i].gaps) check($sformatf("v%0d_stalls", i), 32'(stalls), 32'd0);
            check($sformatf("v%0d_done", i), 32'(done), 32'(vecs[i].exp_done));
            check($sformatf("v%0d_error", i), 32'(error), 32'(vecs[i].exp_error));
            check($sformatf("v%0d_cpu_hold", i), 32'(cpu_hold), 32'(!vecs[i].exp_done));
            check($sformatf("v%0d_rx_ready", i), 32'(rx_ready), 32'd0);
            check($sformatf("v%0d_words", i), 32'(words_loaded), 32'(vecs[i].exp_words));
            check($sformatf("v%0d_nwrites", i), 32'(wr_addr.size()), 32'(vecs[i].exp_nwr));
            if (wr_addr.size() == vecs[i].exp_nwr) begin
                for (int w = 0; w < vecs[i].exp_nwr; w++) begin
                    check($sformatf("v%0d_addr%0d", i, w), wr_addr[w], vecs[i].exp_addr[w]);
                    check($sformatf("v%0d_data%0d", i, w), wr_data[w], vecs[i].exp_data[w]);
                end
            end
            $display("frame %0d: bytes=%0d gaps=%0b done=%0b error=%0b words=%0d writes=%0d",
                     i, vecs[i].nbytes, vecs[i].gaps, done, error, words_loaded, wr_addr.size());
        end

        // Reset after two data bytes of word 0: no write, back to idle with CPU held.
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_bytes({8'h01,8'h00,8'h13,8'h05,{12{8'h00}}}, 4, 1'b0, stalls);
        reset = 1'b1;
        #1;
        check("rst2_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst2_rx_ready", 32'(rx_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst2_nwrites", 32'(wr_addr.size()), 32'd0);
        check("rst2_idle_ready", 32'(rx_ready), 32'd0);
        check("rst2_words", 32'(words_loaded), 32'd0);
        $display("reset after 2 data bytes: writes=%0d hold=%0b", wr_addr.size(), cpu_hold);

        // Write pulse one cycle after the 4th byte, and reset kills it at once.
        @(posedge clk);
        #1;
        pulse_start();
        send_bytes({8'h01,8'h00,8'h13,8'h05,8'hA0,8'h00,{10{8'h00}}}, 6, 1'b0, stalls);
        check("lat_im_we", 32'(im_we), 32'd1);
        check("lat_wdata", im_wdata, 32'h00A0_0513);
        check("lat_ready", 32'(rx_ready), 32'd1);
        reset = 1'b1;
        #1;
        check("rst3_im_we", 32'(im_we), 32'd0);
        check("rst3_im_addr", im_addr, 32'h0);
        check("rst3_cpu_hold", 32'(cpu_hold), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        $display("write latency / reset drop: im_we=%0b", im_we);

        // N == 2**ADDR_WIDTH is the largest legal length.
        @(posedge clk);
        #1;
        pulse_start();
        send_bytes({8'h00,8'h01,{14{8'h00}}}, 2, 1'b0, stalls);
        @(negedge clk);
        check("max_len_error", 32'(error), 32'd0);
        check("max_len_ready", 32'(rx_ready), 32'd1);
        $display("max length 256: error=%0b rx_ready=%0b", error, rx_ready);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule
